// File: rtl/texture_pkg.sv
// Shared definitions for the texture fetch unit: state encoding, RGBA field
// positions inside a 32-bit texel word and the descriptor table entry layout.
package texture_pkg;

    // Texel RAM address width the descriptor entries are sized for.
    localparam int TEX_ADDR_W = 17;

    typedef enum logic [1:0] {
        TEX_IDLE   = 2'd0,
        TEX_LOAD   = 2'd1,
        TEX_ACTIVE = 2'd2
    } tex_state_e;

    // Plain-vector state constants for the legacy-style state register.
    localparam logic [1:0] ST_IDLE   = TEX_IDLE;
    localparam logic [1:0] ST_LOAD   = TEX_LOAD;
    localparam logic [1:0] ST_ACTIVE = TEX_ACTIVE;

    // Bit offsets of each colour channel inside a texel word.
    localparam int RED_LSB   = 24;
    localparam int GREEN_LSB = 16;
    localparam int BLUE_LSB  = 8;
    localparam int ALPHA_LSB = 0;

    typedef struct packed {
        logic [TEX_ADDR_W-1:0] base;
        logic [TEX_ADDR_W-1:0] len;
    } tex_desc_t;

    // Extract one 8-bit channel from a texel word.
    function automatic logic [7:0] rgba_field(input logic [31:0] word, input int unsigned lsb);
        return word[lsb +: 8];
    endfunction

endpackage

// File: rtl/texture_fetch_unit_if.sv
// Bus bundle of the texture fetch unit: bind/fetch handshakes, pixel stream,
// descriptor write port and texel RAM write port.
interface texture_fetch_unit_if #(
    parameter int ADDR_W    = 17,
    parameter int TEX_IDX_W = 8
);
    logic [TEX_IDX_W-1:0] tex_num;
    logic                 load_texture;
    logic                 load_ready;
    logic                 get_rgba;
    logic                 get_ready;
    logic [7:0]           red;
    logic [7:0]           green;
    logic [7:0]           blue;
    logic [7:0]           alpha;
    logic                 pix_valid;
    logic                 pix_last;
    logic                 pix_ready;
    logic                 tex_err;
    logic                 busy;
    logic                 desc_we;
    logic [TEX_IDX_W-1:0] desc_idx;
    logic [ADDR_W-1:0]    desc_base;
    logic [ADDR_W-1:0]    desc_len;
    logic                 write;
    logic [ADDR_W-1:0]    write_address;
    logic [31:0]          write_data;

    // Rasteriser / host side.
    modport master (
        output tex_num, load_texture, get_rgba, pix_ready,
        output desc_we, desc_idx, desc_base, desc_len,
        output write, write_address, write_data,
        input  load_ready, get_ready, red, green, blue, alpha,
        input  pix_valid, pix_last, tex_err, busy
    );

    // Fetch unit side.
    modport slave (
        input  tex_num, load_texture, get_rgba, pix_ready,
        input  desc_we, desc_idx, desc_base, desc_len,
        input  write, write_address, write_data,
        output load_ready, get_ready, red, green, blue, alpha,
        output pix_valid, pix_last, tex_err, busy
    );
endinterface

// File: rtl/texture_ram.sv
// Simple dual-port texel store: one write port, one synchronous read port.
// A read and a write to the same address in one cycle returns the old word.
module texture_ram #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);
    logic [31:0] mem_r [2**ADDR_W];
    logic [31:0] rdata_r;

    // Write port and registered read port; old data wins on address collision.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;
endmodule

// File: rtl/texture_fetch_unit.sv
// Texture fetch engine: binds a texture from the descriptor table, streams its
// texels from the texel RAM in address order (wrapping at the end) through a
// credit-limited output FIFO. Invalid binds are rejected with a tex_err pulse.
module texture_fetch_unit
    import texture_pkg::*;
#(
    parameter int ADDR_W    = TEX_ADDR_W,
    parameter int TEX_IDX_W = 8,
    parameter int NUM_TEX   = 64,
    parameter int OUT_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    texture_fetch_unit_if.slave   bus
);
    localparam int DESC_IDX_W = (NUM_TEX > 1) ? $clog2(NUM_TEX) : 1;
    localparam int PTR_W      = $clog2(OUT_DEPTH);
    localparam int CNT_W      = $clog2(OUT_DEPTH + 1);
    localparam int IDX_XW     = TEX_IDX_W + 1;
    localparam int CRD_W      = CNT_W + 1;
    localparam logic [IDX_XW-1:0] NUM_TEX_L = IDX_XW'(NUM_TEX);
    localparam logic [CRD_W-1:0]  DEPTH_L   = CRD_W'(OUT_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_MAX   = PTR_W'(OUT_DEPTH - 1);

    // Circular FIFO pointer increment for any depth.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_MAX) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Binding / fetch state.
    logic [1:0]            state_r;
    logic [DESC_IDX_W-1:0] tex_sel_r;
    logic [ADDR_W-1:0]     base_r;
    logic [ADDR_W-1:0]     len_r;
    logic [ADDR_W-1:0]     ptr_r;
    logic                  tex_err_r;
    tex_desc_t             desc_tab_r [NUM_TEX];

    // Read pipeline: a read is in flight during the cycle after acceptance.
    logic                  rd_valid_r;
    logic                  rd_last_r;
    logic [31:0]           ram_rdata_s;

    // Output FIFO of {texel, last}.
    logic [32:0]           fifo_mem_r [OUT_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;

    logic                  pix_valid_s;
    logic                  pop_s;
    logic                  load_ready_s;
    logic                  load_acc_s;
    logic                  load_bad_s;
    logic [ADDR_W-1:0]     tex_len_s;
    logic [CRD_W-1:0]      credit_s;
    logic                  get_ready_s;
    logic                  get_acc_s;
    logic [ADDR_W-1:0]     last_addr_s;
    logic                  ptr_last_s;
    logic [CNT_W-1:0]      count_nxt_s;
    logic [32:0]           head_s;

    texture_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (bus.write),
        .waddr (bus.write_address),
        .wdata (bus.write_data),
        .re    (get_acc_s),
        .raddr (ptr_r),
        .rdata (ram_rdata_s)
    );

    // Handshake decisions, credit check and FIFO occupancy update.
    always_comb begin
        pix_valid_s  = (count_r != {CNT_W{1'b0}});
        pop_s        = pix_valid_s & bus.pix_ready;
        load_ready_s = (state_r != ST_LOAD) & ~rd_valid_r;
        load_acc_s   = bus.load_texture & load_ready_s;
        tex_len_s    = ADDR_W'(desc_tab_r[bus.tex_num[DESC_IDX_W-1:0]].len);
        if ({1'b0, bus.tex_num} >= NUM_TEX_L) begin
            load_bad_s = 1'b1;
        end else begin
            load_bad_s = (tex_len_s == {ADDR_W{1'b0}});
        end
        // Texels already owned by the buffer once this cycle's pop retires.
        credit_s     = {1'b0, count_r} + {{CNT_W{1'b0}}, rd_valid_r} - {{CNT_W{1'b0}}, pop_s};
        get_ready_s  = (state_r == ST_ACTIVE) & ~bus.load_texture & (credit_s < DEPTH_L);
        get_acc_s    = bus.get_rgba & get_ready_s;
        last_addr_s  = base_r + len_r - ADDR_W'(1);
        ptr_last_s   = (ptr_r == last_addr_s);
        count_nxt_s  = count_r;
        if (rd_valid_r && !pop_s) begin
            count_nxt_s = count_r + CNT_W'(1);
        end else if (pop_s && !rd_valid_r) begin
            count_nxt_s = count_r - CNT_W'(1);
        end else begin
            count_nxt_s = count_r;
        end
        head_s = fifo_mem_r[rd_ptr_r];
    end

    // Bind state machine, texel address pointer and reject pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            tex_sel_r <= {DESC_IDX_W{1'b0}};
            base_r    <= {ADDR_W{1'b0}};
            len_r     <= {ADDR_W{1'b0}};
            ptr_r     <= {ADDR_W{1'b0}};
            tex_err_r <= 1'b0;
        end else begin
            tex_err_r <= load_acc_s & load_bad_s;
            case (state_r)
                ST_IDLE: begin
                    if (load_acc_s && !load_bad_s) begin
                        state_r   <= ST_LOAD;
                        tex_sel_r <= bus.tex_num[DESC_IDX_W-1:0];
                    end
                end
                ST_LOAD: begin
                    base_r  <= ADDR_W'(desc_tab_r[tex_sel_r].base);
                    len_r   <= ADDR_W'(desc_tab_r[tex_sel_r].len);
                    ptr_r   <= ADDR_W'(desc_tab_r[tex_sel_r].base);
                    state_r <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (load_acc_s && !load_bad_s) begin
                        state_r   <= ST_LOAD;
                        tex_sel_r <= bus.tex_num[DESC_IDX_W-1:0];
                    end else if (get_acc_s) begin
                        ptr_r <= ptr_last_s ? base_r : ptr_r + ADDR_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Descriptor table; writes only become visible to a later LOAD.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_TEX; i++) begin
                desc_tab_r[i].base <= {TEX_ADDR_W{1'b0}};
                desc_tab_r[i].len  <= {TEX_ADDR_W{1'b0}};
            end
        end else if (bus.desc_we && ({1'b0, bus.desc_idx} < NUM_TEX_L)) begin
            desc_tab_r[bus.desc_idx[DESC_IDX_W-1:0]].base <= TEX_ADDR_W'(bus.desc_base);
            desc_tab_r[bus.desc_idx[DESC_IDX_W-1:0]].len  <= TEX_ADDR_W'(bus.desc_len);
        end
    end

    // Track the RAM read in flight and its end-of-texture tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_r <= 1'b0;
            rd_last_r  <= 1'b0;
        end else begin
            rd_valid_r <= get_acc_s;
            rd_last_r  <= ptr_last_s;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (rd_valid_r) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r <= count_nxt_s;
        end
    end

    // FIFO storage; the returning RAM word is captured with its last tag.
    always_ff @(posedge clk) begin
        if (rd_valid_r) begin
            fifo_mem_r[wr_ptr_r] <= {ram_rdata_s, rd_last_r};
        end
    end

    assign bus.pix_valid  = pix_valid_s;
    assign bus.pix_last   = pix_valid_s & head_s[0];
    assign bus.red        = pix_valid_s ? rgba_field(head_s[32:1], RED_LSB)   : 8'h00;
    assign bus.green      = pix_valid_s ? rgba_field(head_s[32:1], GREEN_LSB) : 8'h00;
    assign bus.blue       = pix_valid_s ? rgba_field(head_s[32:1], BLUE_LSB)  : 8'h00;
    assign bus.alpha      = pix_valid_s ? rgba_field(head_s[32:1], ALPHA_LSB) : 8'h00;
    assign bus.load_ready = load_ready_s;
    assign bus.get_ready  = get_ready_s;
    assign bus.tex_err    = tex_err_r;
    assign bus.busy       = rd_valid_r | pix_valid_s;
endmodule

// File: doc/texture_fetch_unit.md
# texture_fetch_unit

Parametrised texture fetch engine between the Input Controller/Rasteriser and the Alpha Blender. Per-texture start addresses and lengths live in a runtime-writable descriptor table. A bound texture is streamed pixel-by-pixel from an internal texel RAM through a credit-limited output buffer with valid/ready handshake, wrapping at the texture end. Out-of-range or empty textures are rejected with an error flag.

## Interface
- ADDR_W, 17, texel RAM address width (depth 2^ADDR_W words)
- TEX_IDX_W, 8, width of texture number
- NUM_TEX, 64, descriptor table entries (valid tex_num 0..NUM_TEX-1)
- OUT_DEPTH, 4, output buffer depth (>=2)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- tex_num  in  TEX_IDX_W  texture to bind on load
- load_texture  in  1  bind request
- load_ready  out  1  bind accepted when load_texture & load_ready
- get_rgba  in  1  fetch request for next texel
- get_ready  out  1  fetch accepted when get_rgba & get_ready
- red, green, blue, alpha  out  8 each  texel fields: word[31:24], [23:16], [15:8], [7:0]
- pix_valid  out  1  output texel valid
- pix_last  out  1  texel came from the last address of the texture
- pix_ready  in  1  consumer accepts texel
- tex_err  out  1  one-cycle pulse: rejected load
- busy  out  1  fetch in flight or buffer non-empty
- desc_we  in  1  descriptor write strobe
- desc_idx  in  TEX_IDX_W  descriptor index
- desc_base  in  ADDR_W  texture start address
- desc_len  in  ADDR_W  texture length in texels (0 = invalid)
- write  in  1  texel RAM write enable
- write_address  in  ADDR_W  texel RAM write address
- write_data  in  32  texel RAM write data (RGBA)

## Operation
- States: IDLE (nothing bound), LOAD (one cycle), ACTIVE.
- load_ready = (state != LOAD) & (inflight == 0).
- Accepted load: if tex_num >= NUM_TEX or desc_len[tex_num] == 0, pulse tex_err, keep state and binding. Otherwise go to LOAD.
- LOAD latches base, len, ptr = base, then goes to ACTIVE.
- get_ready = (state == ACTIVE) & !load_texture & (count + inflight - pop < OUT_DEPTH).
  - pop = pix_valid & pix_ready.
  - Load wins over a simultaneous get.
- Accepted get: issue RAM read at ptr, tag last = (ptr == base+len-1), then advance ptr.
  - ptr advances to ptr+1, or wraps to base when last.
  - Address arithmetic is modulo 2^ADDR_W.
- Output buffer: FIFO of {data, last}, OUT_DEPTH entries. Head drives the outputs; pop on pix_valid & pix_ready.
- A rebind preserves buffered texels; they drain in order before new-texture texels.
- Descriptor writes take effect at the next LOAD; they never alter the current binding.
- Same-cycle RAM write and read to one address returns old data.
- busy = inflight | (count != 0).

## Timing
- Reset values:
  - state IDLE, ptr/base/len 0, buffer empty.
  - pix_valid, pix_last, tex_err, busy, get_ready = 0; load_ready = 1.
  - red/green/blue/alpha = 0.
  - All descriptor lengths = 0.
- Reset mid-operation discards in-flight reads and buffered texels on the next edge.
- Load accepted at cycle N: LOAD in N+1, get_ready may rise in N+2.
- Get accepted at cycle N: RAM read in N+1, buffer write at end of N+1, pix_valid in N+2. Latency is 2.
- Sustained throughput is 1 texel/cycle while pix_ready is held high.
- Buffer full or pix_ready low: get_ready deasserts and no texel is dropped. Outputs hold stable while pix_valid & !pix_ready.
- tex_err asserts the cycle after the rejected load and lasts one cycle.

## Structure
- Shared package texture_pkg holds:
  - state enum (IDLE, LOAD, ACTIVE)
  - RGBA field offset constants
  - descriptor struct {base, len}
- Sub-module texture_ram: simple dual-port, 2^ADDR_W x 32, synchronous one-cycle read, separate write port.
- FIFO, credit counter and descriptor table stay inline.

## Test plan
- Reset, then desc[3] = {base 100, len 3}, RAM[100..102] = 0x11223344, 0x55667788, 0x99AABBCC. Load 3, then 4 gets with pix_ready = 1. Expected:
  - texels 0x11223344, 0x55667788, 0x99AABBCC, 0x11223344
  - pix_last on the third texel
  - first pix_valid 2 cycles after the first accepted get
- Load tex_num = 64, then load tex_num = 5 with len 0 -> tex_err pulses each time, state and binding unchanged.
- pix_ready = 0 with get_rgba held high -> exactly OUT_DEPTH (4) gets accepted, then get_ready = 0. Releasing pix_ready drains in order.
- load_texture and get_rgba in the same cycle -> load accepted, get not accepted. The previous texture's buffered texels emerge before the new one's.
- desc base = 2^17-2, len 4 -> addresses 131070, 131071, 0, 1, then wrap to 131070 with pix_last on address 1.
- Assert reset with 2 texels buffered -> next cycle pix_valid = 0, busy = 0, state IDLE.
